// File: rtl/mem_bank_2rw_arbiter.sv
// mem_bank_2rw_arbiter
//
// Round-robin arbiter/sequencer sharing one dual-port masked register bank
// (two RW ports, bit-level write mask, asynchronous read) among NUM_REQ
// requesters. Up to two non-conflicting requests are granted per cycle, one
// per bank port, and each granted request gets a registered response pulse
// one cycle later.
//
// Optional feature macro: MEM_BANK_ARB_INIT_EN
//   defined   -> an INIT phase zeroes every bank entry after each reset
//                before any request is accepted; init_done rises after it.
//   undefined -> the block arbitrates right after reset; init_done is 1.
//
// Parameters: NUM_REQ (>=2), REG_DEPTH (>=2), REG_WIDTH.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   req_valid/req_ready     per-requester handshake (ready is combinational)
//   req_wmode               1 = write, 0 = read
//   req_addr                flattened, requester i at [i*AW +: AW]
//   req_wmask/req_wdata     flattened, requester i at [i*REG_WIDTH +: REG_WIDTH]
//   resp_valid/resp_rdata   one-cycle response; rdata is zero for writes
//   init_done               bank usable
//   RW0_*/RW1_*             bank port drive and asynchronous read data
//
// While reset is high every output except init_done is forced to zero, so a
// response registered just before reset is never presented.

module mem_bank_2rw_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REG_DEPTH = 4,
    parameter int REG_WIDTH = 64,
    localparam int AW = $clog2(REG_DEPTH),
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_wmode,
    input  logic [NUM_REQ*AW-1:0]        req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_wmask,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [NUM_REQ*REG_WIDTH-1:0] resp_rdata,
    output logic                         init_done,
    output logic                         RW0_wmode,
    output logic [AW-1:0]                RW0_addr,
    output logic [REG_WIDTH-1:0]         RW0_wmask,
    output logic [REG_WIDTH-1:0]         RW0_wdata,
    input  logic [REG_WIDTH-1:0]         RW0_rdata,
    output logic                         RW1_wmode,
    output logic [AW-1:0]                RW1_addr,
    output logic [REG_WIDTH-1:0]         RW1_wmask,
    output logic [REG_WIDTH-1:0]         RW1_wdata,
    input  logic [REG_WIDTH-1:0]         RW1_rdata
);

    // (base + off) mod NUM_REQ, valid for any NUM_REQ, not only powers of 2.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return PW'(sum % NUM_REQ);
    endfunction

    logic [PW-1:0]                rr_ptr;
    logic                         running;
    logic                         g0_vld_p0;
    logic                         g1_vld_p0;
    logic [PW-1:0]                g0_idx_p0;
    logic [PW-1:0]                g1_idx_p0;
    logic [PW-1:0]                cand;
    logic [NUM_REQ-1:0]           resp_vld_p1;
    logic [NUM_REQ*REG_WIDTH-1:0] resp_data_p1;

`ifdef MEM_BANK_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t        state;
    logic [AW:0]   init_cnt;
    logic          init_done_r;
    logic          init_active;

    assign running     = !reset && (state == ST_RUN);
    assign init_active = !reset && (state == ST_INIT);
    assign init_done   = init_done_r;
`else
    assign running   = !reset;
    assign init_done = 1'b1;
`endif

    // Stage p0: grant selection. Port 0 takes the first valid requester at or
    // after rr_ptr; port 1 the next valid one after it that does not collide
    // (same address with a write on either side). Everything between rr_ptr
    // and the port 0 winner is idle, so searching from the winner covers all.
    always_comb begin
        g0_vld_p0 = 1'b0;
        g0_idx_p0 = '0;
        g1_vld_p0 = 1'b0;
        g1_idx_p0 = '0;
        cand      = '0;
        if (running) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = wrap_idx(rr_ptr, k);
                if (!g0_vld_p0 && req_valid[cand]) begin
                    g0_vld_p0 = 1'b1;
                    g0_idx_p0 = cand;
                end
            end
            for (int k = 1; k < NUM_REQ; k++) begin
                cand = wrap_idx(g0_idx_p0, k);
                if (g0_vld_p0 && !g1_vld_p0 && req_valid[cand] &&
                    !((req_addr[cand*AW +: AW] == req_addr[g0_idx_p0*AW +: AW]) &&
                      (req_wmode[cand] || req_wmode[g0_idx_p0]))) begin
                    g1_vld_p0 = 1'b1;
                    g1_idx_p0 = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (g0_vld_p0) req_ready[g0_idx_p0] = 1'b1;
        if (g1_vld_p0) req_ready[g1_idx_p0] = 1'b1;
    end

    always_comb begin
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        RW1_wmode = 1'b0;
        RW1_addr  = '0;
        RW1_wmask = '0;
        RW1_wdata = '0;
        if (g0_vld_p0) begin
            RW0_wmode = req_wmode[g0_idx_p0];
            RW0_addr  = req_addr[g0_idx_p0*AW +: AW];
            RW0_wmask = req_wmask[g0_idx_p0*REG_WIDTH +: REG_WIDTH];
            RW0_wdata = req_wdata[g0_idx_p0*REG_WIDTH +: REG_WIDTH];
        end
        if (g1_vld_p0) begin
            RW1_wmode = req_wmode[g1_idx_p0];
            RW1_addr  = req_addr[g1_idx_p0*AW +: AW];
            RW1_wmask = req_wmask[g1_idx_p0*REG_WIDTH +: REG_WIDTH];
            RW1_wdata = req_wdata[g1_idx_p0*REG_WIDTH +: REG_WIDTH];
        end
`ifdef MEM_BANK_ARB_INIT_EN
        // Zero two entries per cycle; the odd tail entry is skipped on port 1.
        if (init_active) begin
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt[AW-1:0];
            RW0_wmask = '1;
            if (int'(init_cnt) + 1 < REG_DEPTH) begin
                RW1_wmode = 1'b1;
                RW1_addr  = AW'(init_cnt + (AW+1)'(1));
                RW1_wmask = '1;
            end
        end
`endif
    end

    // Stage p1: registered responses and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            resp_vld_p1  <= '0;
            resp_data_p1 <= '0;
`ifdef MEM_BANK_ARB_INIT_EN
            state        <= ST_INIT;
            init_cnt     <= '0;
            init_done_r  <= 1'b0;
`endif
        end else begin
            resp_vld_p1  <= req_ready;
            resp_data_p1 <= '0;
            if (g0_vld_p0 && !req_wmode[g0_idx_p0])
                resp_data_p1[g0_idx_p0*REG_WIDTH +: REG_WIDTH] <= RW0_rdata;
            if (g1_vld_p0 && !req_wmode[g1_idx_p0])
                resp_data_p1[g1_idx_p0*REG_WIDTH +: REG_WIDTH] <= RW1_rdata;
            if (g1_vld_p0)
                rr_ptr <= wrap_idx(g1_idx_p0, 1);
            else if (g0_vld_p0)
                rr_ptr <= wrap_idx(g0_idx_p0, 1);
`ifdef MEM_BANK_ARB_INIT_EN
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + (AW+1)'(2);
                if (int'(init_cnt) + 2 >= REG_DEPTH) begin
                    state       <= ST_RUN;
                    init_done_r <= 1'b1;
                end
            end
`endif
        end
    end

    assign resp_valid = reset ? '0 : resp_vld_p1;
    assign resp_rdata = reset ? '0 : resp_data_p1;

endmodule

// File: tb/tb_mem_bank_2rw_arbiter.sv
// Bench for mem_bank_2rw_arbiter: a behavioural dual-port masked bank is
// attached to the RW ports, and a reference model (requester list ordered
// from the round-robin pointer, plus an array-based memory image) predicts
// grants, responses and read data every cycle.

module tb_mem_bank_2rw_arbiter;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int W  = 64;
    localparam int AW = 2;
`ifdef MEM_BANK_ARB_INIT_EN
    localparam int INIT_CYC = (D + 1) / 2;
    localparam bit INIT_ON  = 1'b1;
`else
    localparam int INIT_CYC = 0;
    localparam bit INIT_ON  = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wmode;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wmask;
    logic [N*W-1:0]  req_wdata;
    logic [N-1:0]    resp_valid;
    logic [N*W-1:0]  resp_rdata;
    logic            init_done;
    logic            RW0_wmode, RW1_wmode;
    logic [AW-1:0]   RW0_addr, RW1_addr;
    logic [W-1:0]    RW0_wmask, RW0_wdata, RW0_rdata;
    logic [W-1:0]    RW1_wmask, RW1_wdata, RW1_rdata;

    always #5 clock = ~clock;

    mem_bank_2rw_arbiter #(.NUM_REQ(N), .REG_DEPTH(D), .REG_WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wmode(req_wmode),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .init_done(init_done),
        .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr), .RW0_wmask(RW0_wmask),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
        .RW1_wmode(RW1_wmode), .RW1_addr(RW1_addr), .RW1_wmask(RW1_wmask),
        .RW1_wdata(RW1_wdata), .RW1_rdata(RW1_rdata)
    );

    // Register bank: asynchronous read, bit-masked write on the clock edge.
    logic [W-1:0] bank [D];
    bit scramble = 1'b1;
    assign RW0_rdata = bank[RW0_addr];
    assign RW1_rdata = bank[RW1_addr];
    always @(posedge clock) begin
        if (scramble) begin
            for (int a = 0; a < D; a++) bank[a] <= {$urandom, $urandom};
        end else begin
            if (RW0_wmode) bank[RW0_addr] <= (bank[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
            if (RW1_wmode) bank[RW1_addr] <= (bank[RW1_addr] & ~RW1_wmask) | (RW1_wdata & RW1_wmask);
        end
    end

    int checks = 0;
    int errors = 0;

    // Pending request of each requester.
    logic [N-1:0]  p_valid, p_wmode;
    logic [AW-1:0] p_addr [N];
    logic [W-1:0]  p_mask [N];
    logic [W-1:0]  p_data [N];

    // Reference model state.
    int           m_rr = 0;
    int           m_init_left = INIT_CYC;
    logic [W-1:0] m_mem [D];
    bit           m_known [D];
    logic [N-1:0] exp_rv = '0;
    logic [W-1:0] exp_rd [N];
    bit           exp_rd_known [N];

    typedef struct {
        logic [N-1:0]    valid;
        logic [N-1:0]    wmode;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    exp_ready;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = p_valid[i];
            req_wmode[i]           = p_wmode[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_wmask[i*W +: W]    = p_mask[i];
            req_wdata[i*W +: W]    = p_data[i];
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic wm, input logic [AW-1:0] a,
                           input logic [W-1:0] m, input logic [W-1:0] d);
        p_valid[i] = v;
        p_wmode[i] = wm;
        p_addr[i]  = a;
        p_mask[i]  = m;
        p_data[i]  = d;
    endtask

    // Valid requesters listed in round-robin order from m_rr; the first one
    // wins port 0, the first later one that does not collide wins port 1.
    function automatic void pick(output int w0, output int w1);
        int order [$];
        w0 = -1;
        w1 = -1;
        if (reset || m_init_left > 0) return;
        for (int k = 0; k < N; k++)
            if (p_valid[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
        if (order.size() == 0) return;
        w0 = order[0];
        for (int j = 1; j < order.size(); j++) begin
            int c;
            c = order[j];
            if (!(p_addr[c] == p_addr[w0] && (p_wmode[c] || p_wmode[w0]))) begin
                w1 = c;
                break;
            end
        end
    endfunction

    function automatic void commit(input int w0, input int w1);
        int ws [2];
        int last;
        ws[0] = w0;
        ws[1] = w1;
        exp_rv = '0;
        if (reset) begin
            m_rr = 0;
            m_init_left = INIT_CYC;
            if (INIT_ON)
                for (int a = 0; a < D; a++) begin
                    m_mem[a]   = '0;
                    m_known[a] = 1'b1;
                end
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            foreach (ws[j]) if (ws[j] >= 0) begin
                exp_rv[ws[j]] = 1'b1;
                exp_rd[ws[j]]       = p_wmode[ws[j]] ? '0 : m_mem[p_addr[ws[j]]];
                exp_rd_known[ws[j]] = p_wmode[ws[j]] ? 1'b1 : m_known[p_addr[ws[j]]];
            end
            foreach (ws[j]) if (ws[j] >= 0 && p_wmode[ws[j]]) begin
                m_mem[p_addr[ws[j]]] = (m_mem[p_addr[ws[j]]] & ~p_mask[ws[j]]) |
                                       (p_data[ws[j]] & p_mask[ws[j]]);
                m_known[p_addr[ws[j]]] = m_known[p_addr[ws[j]]] || (p_mask[ws[j]] == '1);
            end
            last = (w1 >= 0) ? w1 : w0;
            if (last >= 0) m_rr = (last + 1) % N;
            foreach (ws[j]) if (ws[j] >= 0) p_valid[ws[j]] = 1'b0;
        end
    endfunction

    // One clock cycle: drive, check on the falling edge, update the model on
    // the rising edge, return 1 time unit after it.
    task automatic step(input bit do_chk, input bit use_tbl, input logic [N-1:0] tbl_ready);
        int w0, w1;
        logic [N-1:0] er;
        apply_inputs();
        @(negedge clock);
        pick(w0, w1);
        er = '0;
        if (w0 >= 0) er[w0] = 1'b1;
        if (w1 >= 0) er[w1] = 1'b1;
        if (do_chk) begin
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("resp_valid", 64'(resp_valid), reset ? 64'(0) : 64'(exp_rv));
            for (int i = 0; i < N; i++)
                if (!reset && exp_rv[i] && exp_rd_known[i])
                    chk("resp_rdata", resp_rdata[i*W +: W], exp_rd[i]);
            chk("init_done", 64'(init_done), 64'(m_init_left == 0));
            if (use_tbl) chk("tbl_ready", 64'(req_ready), 64'(tbl_ready));
        end
        @(posedge clock);
        commit(w0, w1);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 8'hE4, 4'b0011};
        tbl[1]  = '{4'b1100, 4'b0000, 8'hE4, 4'b1100};
        tbl[2]  = '{4'b0011, 4'b0001, 8'h0A, 4'b0001};
        tbl[3]  = '{4'b0010, 4'b0000, 8'h0A, 4'b0010};
        tbl[4]  = '{4'b1010, 4'b0000, 8'hCC, 4'b1010};
        tbl[5]  = '{4'b1111, 4'b0101, 8'h15, 4'b1100};
        tbl[6]  = '{4'b0011, 4'b0001, 8'h15, 4'b0001};
        tbl[7]  = '{4'b0010, 4'b0000, 8'h15, 4'b0010};
        tbl[8]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000};
        tbl[9]  = '{4'b0011, 4'b0010, 8'h00, 4'b0001};
        tbl[10] = '{4'b0010, 4'b0010, 8'h00, 4'b0010};
        tbl[11] = '{4'b1001, 4'b1001, 8'hC3, 4'b1000};
        tbl[12] = '{4'b0001, 4'b1001, 8'hC3, 4'b0001};
        tbl[13] = '{4'b1111, 4'b0000, 8'hE4, 4'b0110};
        for (int a = 0; a < D; a++) begin
            m_mem[a]   = '0;
            m_known[a] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 1'b0, '0, '0, '0);
            exp_rd[i]       = '0;
            exp_rd_known[i] = 1'b0;
        end

        // Reset state.
        reset = 1'b1;
        step(1'b0, 1'b0, '0);
        scramble = 1'b0;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_rdata_zero", 64'(resp_rdata == '0), 64'(1));
        chk("rst_rw0_wmode", 64'(RW0_wmode), 64'(0));
        chk("rst_rw1_wmode", 64'(RW1_wmode), 64'(0));
        chk("rst_rw0_addr", 64'(RW0_addr), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(!INIT_ON));
        step(1'b1, 1'b0, '0);
        reset = 1'b0;
        #1;
`ifdef MEM_BANK_ARB_INIT_EN
        chk("init1_rw0_wmode", 64'(RW0_wmode), 64'(1));
        chk("init1_rw0_addr", 64'(RW0_addr), 64'(0));
        chk("init1_rw0_wmask", RW0_wmask, '1);
        chk("init1_rw0_wdata", RW0_wdata, 64'(0));
        chk("init1_rw1_wmode", 64'(RW1_wmode), 64'(1));
        chk("init1_rw1_addr", 64'(RW1_addr), 64'(1));
        step(1'b1, 1'b0, '0);
        chk("init2_rw0_addr", 64'(RW0_addr), 64'(2));
        chk("init2_rw1_addr", 64'(RW1_addr), 64'(3));
        chk("init2_rw1_wmode", 64'(RW1_wmode), 64'(1));
        chk("init2_init_done", 64'(init_done), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("init3_init_done", 64'(init_done), 64'(1));
        chk("init3_rw0_idle", 64'(RW0_wmode), 64'(0));
`else
        chk("run_init_done", 64'(init_done), 64'(1));
        chk("run_rw0_idle", 64'(RW0_wmode), 64'(0));
`endif

        // Table-driven arbitration, starting from rr_ptr = 0.
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < N; i++)
                set_req(i, tbl[r].valid[i], tbl[r].wmode[i], tbl[r].addr[i*AW +: AW],
                        '1, {32'hC0DE_0000, 32'(i)});
            step(1'b1, 1'b1, tbl[r].exp_ready);
        end
        p_valid = '0;
        step(1'b1, 1'b0, '0);

        // Write then read of the same entry on later cycles.
        set_req(0, 1'b1, 1'b1, 2'd1, '1, 64'hDEAD_BEEF);
        step(1'b1, 1'b0, '0);
        set_req(2, 1'b1, 1'b0, 2'd1, '0, '0);
        step(1'b1, 1'b0, '0);
        chk("deadbeef_vld", 64'(resp_valid), 64'(4'b0100));
        chk("deadbeef_data", resp_rdata[2*W +: W], 64'hDEAD_BEEF);

        // Bit-masked write.
        set_req(1, 1'b1, 1'b1, 2'd0, '1, 64'hFFFF);
        step(1'b1, 1'b0, '0);
        set_req(1, 1'b1, 1'b1, 2'd0, 64'h00FF, 64'h0);
        step(1'b1, 1'b0, '0);
        set_req(3, 1'b1, 1'b0, 2'd0, '0, '0);
        step(1'b1, 1'b0, '0);
        chk("mask_vld", 64'(resp_valid), 64'(4'b1000));
        chk("mask_data", resp_rdata[3*W +: W], 64'hFF00);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (!p_valid[i] && $urandom_range(0, 9) < 6)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D-1)),
                            ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom},
                            {$urandom, $urandom});
            step(1'b1, 1'b0, '0);
        end
        p_valid = '0;
        step(1'b1, 1'b0, '0);

        // Reset one cycle after a read grant: the response is dropped.
        set_req(0, 1'b1, 1'b0, 2'd1, '0, '0);
        step(1'b1, 1'b0, '0);
        set_req(1, 1'b1, 1'b0, 2'd2, '0, '0);
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("midrst_after_edge", 64'(resp_valid), 64'(0));
        reset = 1'b0;
        #1;
`ifdef MEM_BANK_ARB_INIT_EN
        chk("midrst_init_restart", 64'(RW0_wmode), 64'(1));
        chk("midrst_init_addr", 64'(RW0_addr), 64'(0));
        chk("midrst_init_done", 64'(init_done), 64'(0));
`else
        chk("midrst_init_done", 64'(init_done), 64'(1));
`endif
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
